// File: rtl/neuron_layer_sched.sv
// Layer-pass scheduler: fetches each neuron's weights, hands them to an
// external MAC, and collects one result per neuron into y_flat.
module neuron_layer_sched #(
   parameter int NUM_NEURONS = 4,
   parameter int NUM_INPUTS  = 8,
   parameter int X_W         = 8,
   parameter int W_W         = 8,
   parameter int B_W         = 32,
   parameter int OUT_W       = 16,
   parameter int TIMEOUT     = 255,
   localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int TW = $clog2(TIMEOUT + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [NUM_INPUTS*X_W-1:0]     x_flat,
   input  logic [1:0]                    act_sel,
   input  logic [NUM_INPUTS-1:0]         mask_flat,
   output logic                          wmem_rd,
   output logic [AW-1:0]                 wmem_addr,
   input  logic [NUM_INPUTS*W_W-1:0]     wmem_w,
   input  logic [B_W-1:0]                wmem_bias,
   output logic                          mac_in_valid,
   input  logic                          mac_in_ready,
   output logic [NUM_INPUTS*X_W-1:0]     mac_x_flat,
   output logic [NUM_INPUTS*W_W-1:0]     mac_w_flat,
   output logic [B_W-1:0]                mac_bias,
   output logic [1:0]                    mac_act_sel,
   output logic [NUM_INPUTS-1:0]         mac_mask,
   input  logic                          mac_out_valid,
   input  logic signed [OUT_W-1:0]       mac_out_data,
   output logic [NUM_NEURONS*OUT_W-1:0]  y_flat,
   output logic                          done,
   output logic                          busy,
   output logic                          err
);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, ISSUE, WAIT, DONE
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   state_t                       state_q, state_d;
   logic [AW-1:0]                idx_q, idx_d;
   logic [TW-1:0]                tmo_q, tmo_d;
   logic                         err_q, err_d;
   logic                         cap_en, ld_en, y_we;
   logic [NUM_INPUTS*X_W-1:0]    x_q;
   logic [1:0]                   act_q;
   logic [NUM_INPUTS-1:0]        mask_q;
   logic [NUM_INPUTS*W_W-1:0]    w_q;
   logic [B_W-1:0]               bias_q;
   logic [NUM_NEURONS*OUT_W-1:0] y_q, y_d;

   // Next-state and datapath enables; abort overrides every active state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      cap_en  = 1'b0;
      ld_en   = 1'b0;
      y_we    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = FETCH;
               idx_d   = '0;
               err_d   = 1'b0;
               cap_en  = 1'b1;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            ld_en   = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (mac_in_ready) begin
               state_d = WAIT;
               tmo_d   = '0;
            end
         end
         WAIT: begin
            if (mac_out_valid) begin
               y_we = 1'b1;
               if (idx_q == LAST) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = FETCH;
               end
            end else if (tmo_q == TMAX) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && abort) begin
         state_d = IDLE;
         ld_en   = 1'b0;
         y_we    = 1'b0;
      end
   end

   // Result slot write for the neuron currently in WAIT.
   always_comb begin
      y_d = y_q;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (y_we && idx_q == AW'(i)) begin
            y_d[i*OUT_W +: OUT_W] = mac_out_data;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   // Layer operands, held for the whole pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         act_q  <= '0;
         mask_q <= '0;
      end else if (cap_en) begin
         x_q    <= x_flat;
         act_q  <= act_sel;
         mask_q <= mask_flat;
      end
   end

   // Per-neuron weights and bias from the weight memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q    <= '0;
         bias_q <= '0;
      end else if (ld_en) begin
         w_q    <= wmem_w;
         bias_q <= wmem_bias;
      end
   end

   // Result slots; only WAIT writes change them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign wmem_rd      = (state_q == FETCH);
   assign wmem_addr    = idx_q;
   assign mac_in_valid = (state_q == ISSUE);
   assign mac_x_flat   = x_q;
   assign mac_w_flat   = w_q;
   assign mac_bias     = bias_q;
   assign mac_act_sel  = act_q;
   assign mac_mask     = mask_q;
   assign y_flat       = y_q;
   assign done         = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign err          = err_q;

endmodule

// File: doc/neuron_layer_sched.md
NEURON_LAYER_SCHED -- requirements
Module: neuron_layer_sched

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: neurons evaluated per layer pass.
REQ-002 SHALL have parameter NUM_INPUTS, default 8: inputs per neuron.
REQ-003 SHALL have parameters X_W=8, W_W=8, B_W=32, OUT_W=16: sample, weight, bias and result widths.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles per neuron.
REQ-005 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-006 SHALL have start (in, 1): request a layer pass.
REQ-007 SHALL have abort (in, 1): cancel the pass in progress.
REQ-008 SHALL have x_flat (in, NUM_INPUTS*X_W), act_sel (in, 2) and mask_flat (in, NUM_INPUTS): layer operands, captured on start.
REQ-009 SHALL have wmem_rd (out, 1) and wmem_addr (out, $clog2(NUM_NEURONS)): weight-memory read.
REQ-010 SHALL have wmem_w (in, NUM_INPUTS*W_W) and wmem_bias (in, B_W): read data, valid exactly 1 cycle after wmem_rd.
REQ-011 SHALL have the MAC request port: mac_in_valid (out, 1), mac_in_ready (in, 1), mac_x_flat, mac_w_flat, mac_bias, mac_act_sel, mac_mask (out, widths as the layer operands).
REQ-012 SHALL have the MAC result port: mac_out_valid (in, 1) and mac_out_data (in, OUT_W, signed).
REQ-013 SHALL have y_flat (out, NUM_NEURONS*OUT_W): results, neuron i in bits [i*OUT_W +: OUT_W].
REQ-014 SHALL have done (out, 1), busy (out, 1) and err (out, 1).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LOAD, ISSUE, WAIT, DONE.
REQ-016 In IDLE, start=1 and abort=0: capture x_flat, act_sel and mask_flat; set idx=0; go to FETCH; clear err.
REQ-017 In any state other than IDLE, start SHALL be ignored.
REQ-018 FETCH: assert wmem_rd=1 for exactly one cycle with wmem_addr=idx, then go to LOAD; wmem_rd=0 in all other states.
REQ-019 LOAD: register wmem_w and wmem_bias into mac_w_flat and mac_bias; go to ISSUE.
REQ-020 ISSUE: assert mac_in_valid=1, holding all mac_* data stable until the cycle with mac_in_ready=1; that cycle is the transfer; go to WAIT and clear the timeout counter.
REQ-021 WAIT: on mac_out_valid=1, write mac_out_data into y_flat slot idx. If idx==NUM_NEURONS-1, go to DONE; otherwise increment idx and go to FETCH.
REQ-022 mac_out_valid outside WAIT SHALL be ignored.
REQ-023 WAIT timeout: after TIMEOUT consecutive cycles without mac_out_valid, set err=1 and go to IDLE without done.
REQ-024 err SHALL be sticky until the next accepted start.
REQ-025 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-026 y_flat SHALL change only through WAIT writes; slots hold their values across IDLE.
REQ-027 abort=1 in any non-IDLE state: go to IDLE next cycle; done not asserted; mac_in_valid and wmem_rd deasserted next cycle; y_flat slots already written are kept.
REQ-028 abort=1 and start=1 together in IDLE: abort wins and start is not accepted.
REQ-029 busy=1 in every state except IDLE.
REQ-030 mac_x_flat, mac_act_sel and mac_mask SHALL equal the values captured at start for the whole pass.
REQ-031 Minimum per-neuron latency SHALL be FETCH+LOAD+ISSUE+WAIT = 4 cycles with ready=1 and result in the cycle after transfer.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, idx=0, all captured registers 0, y_flat=0, and mac_in_valid, wmem_rd, done, busy, err all 0.
REQ-033 Reset asserted mid-pass SHALL discard the pass; no done after release.

Verification
REQ-034 MAC model with ready=1 and result (idx+1)*16'h0100 three cycles after transfer; start -> wmem_addr sequence 0,1,2,3; y_flat={0400,0300,0200,0100}; single done pulse; busy falls with done.
REQ-035 mac_in_ready held low 5 cycles in ISSUE -> mac_in_valid stays 1 and mac_w_flat/mac_bias stay constant; exactly one transfer.
REQ-036 start pulsed while busy at idx=1 -> ignored; pass completes normally; captured x unchanged.
REQ-037 abort in WAIT of idx=2 -> busy=0 next cycle; no done; slots 0 and 1 updated, slots 2 and 3 unchanged.
REQ-038 TIMEOUT=8 and no mac_out_valid -> err=1 after 8 WAIT cycles, IDLE; the next start clears err.
REQ-039 rst_n low during ISSUE -> all outputs 0 immediately; no done after release.
